glyph_serialiser: RTL and testbench

GLYPH_SERIALISER -- requirements
Module: glyph_serialiser

---
 rtl/glyph_serialiser_if.sv | 25 ++
 rtl/glyph_serialiser.sv | 72 +++++++
 tb/tb_glyph_serialiser.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_serialiser_if.sv
// Character request, glyph ROM and pixel stream signals of the glyph serialiser.
// The slave modport is the serialiser's view; the master modport is the source/ROM/sink side.
interface glyph_serialiser_if;
  logic       char_valid;
  logic [6:0] char_code;
  logic [2:0] char_row;
  logic       char_invert;
  logic       char_ready;
  logic [6:0] rom_char_index;
  logic [2:0] rom_row_index;
  logic [7:0] rom_dout;
  logic       pixel;
  logic       pixel_valid;
  logic       pixel_last;

  modport slave (
    input  char_valid, char_code, char_row, char_invert, rom_dout,
    output char_ready, rom_char_index, rom_row_index, pixel, pixel_valid, pixel_last
  );

  modport master (
    output char_valid, char_code, char_row, char_invert, rom_dout,
    input  char_ready, rom_char_index, rom_row_index, pixel, pixel_valid, pixel_last
  );
endinterface

// File: rtl/glyph_serialiser.sv
// Turns character-row requests into a serial pixel stream, MSB first, through a
// synchronous glyph ROM: A holds the address, B flags ROM data valid, C shifts pixels.
module glyph_serialiser (
  input logic               clock,
  input logic               reset_n,
  glyph_serialiser_if.slave bus
);
  logic       valid_a, invert_a;
  logic [6:0] code_a;
  logic [2:0] row_a;
  logic       valid_b;
  logic [7:0] shift;
  logic [2:0] count;
  logic       invert_c, busy;
  logic       accept, transfer, last_bit;

  assign last_bit       = busy & (count == 3'd7);
  // C can take a new byte when idle or on the cycle it emits its last pixel,
  // which is what keeps back-to-back glyphs gapless.
  assign transfer       = valid_a & valid_b & (~busy | last_bit);
  assign bus.char_ready = ~valid_a | transfer;
  assign accept         = bus.char_valid & bus.char_ready;

  // Stage A: the held request doubles as the ROM address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_a  <= 1'b0;
      code_a   <= '0;
      row_a    <= '0;
      invert_a <= 1'b0;
    end else if (accept) begin
      valid_a  <= 1'b1;
      code_a   <= bus.char_code;
      row_a    <= bus.char_row;
      invert_a <= bus.char_invert;
    end else if (transfer) begin
      valid_a  <= 1'b0;
    end
  end

  // Stage B: ROM output matches A once the address has been stable for one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                valid_b <= 1'b0;
    else if (accept || transfer) valid_b <= 1'b0;
    else                         valid_b <= valid_a;
  end

  // Stage C: shift register, bit counter and reverse-video flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift    <= '0;
      count    <= '0;
      invert_c <= 1'b0;
      busy     <= 1'b0;
    end else if (transfer) begin
      shift    <= bus.rom_dout;
      count    <= '0;
      invert_c <= invert_a;
      busy     <= 1'b1;
    end else if (busy) begin
      shift    <= {shift[6:0], 1'b0};
      count    <= count + 3'd1;
      if (last_bit) busy <= 1'b0;
    end
  end

  assign bus.rom_char_index = code_a;
  assign bus.rom_row_index  = row_a;
  assign bus.pixel          = busy & (shift[7] ^ invert_c);
  assign bus.pixel_valid    = busy;
  assign bus.pixel_last     = last_bit;
endmodule

// File: tb/tb_glyph_serialiser.sv
// Randomised bench for glyph_serialiser: a timing/pixel reference model computed
// from request acceptance times, plus directed glyph scenarios.
module tb_glyph_serialiser;
  logic clock = 1'b0;
  logic reset_n = 1'b0;

  glyph_serialiser_if bus();

  glyph_serialiser dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Synchronous glyph ROM.
  logic [7:0] rom [0:1023];
  always @(posedge clock) bus.rom_dout <= rom[{bus.rom_char_index, bus.rom_row_index}];

  int tests = 0;
  int fails = 0;

  // Reference model: each accepted request owns 8 pixel cycles starting at
  // max(accept+2, previous start+8); the source is blocked while a request waits.
  int         ecnt   = 0;
  int         last_e = -100;
  int         last_t = -100;
  bit         m_ready = 1'b1;
  bit         m_acc;
  bit         e_pv, e_px, e_pl;
  logic [6:0] e_ci = '0;
  logic [2:0] e_ri = '0;
  bit         exp_pv [int];
  bit         exp_px [int];
  bit         exp_pl [int];
  logic [63:0] glyph_a = 64'h3078CCCCFCCCCC00;

  task automatic model_clear();
    exp_pv.delete();
    exp_px.delete();
    exp_pl.delete();
    last_e  = -100;
    last_t  = -100;
    e_ci    = '0;
    e_ri    = '0;
    m_ready = 1'b1;
    e_pv = 1'b0; e_px = 1'b0; e_pl = 1'b0;
  endtask

  // One clock: update the model at the rising edge, then settle on the falling edge.
  task automatic step();
    int t;
    logic [7:0] b;
    @(posedge clock);
    ecnt++;
    m_acc = 1'b0;
    if (!reset_n) model_clear();
    else if (bus.char_valid && m_ready) begin
      t = (ecnt + 2 > last_t + 8) ? ecnt + 2 : last_t + 8;
      b = rom[{bus.char_code, bus.char_row}] ^ {8{bus.char_invert}};
      for (int k = 0; k < 8; k++) begin
        exp_pv[t+k] = 1'b1;
        exp_px[t+k] = b[7-k];
        exp_pl[t+k] = (k == 7);
      end
      last_e = ecnt;
      last_t = t;
      e_ci   = bus.char_code;
      e_ri   = bus.char_row;
      m_acc  = 1'b1;
    end
    @(negedge clock);
    m_ready = !(last_e < ecnt + 1 && ecnt + 1 < last_t);
    e_pv = exp_pv.exists(ecnt) ? exp_pv[ecnt] : 1'b0;
    e_px = exp_px.exists(ecnt) ? exp_px[ecnt] : 1'b0;
    e_pl = exp_pl.exists(ecnt) ? exp_pl[ecnt] : 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.char_valid = 1'b0; bus.char_code = '0; bus.char_row = '0; bus.char_invert = 1'b0;
    step(); step();
    tests++;
    if ({bus.pixel_valid, bus.pixel, bus.pixel_last} !== 3'b000) begin
      fails++; $display("FAIL reset_outputs got %b want 000", {bus.pixel_valid, bus.pixel, bus.pixel_last});
    end
    tests++;
    if (bus.char_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", bus.char_ready);
    end
    tests++;
    if ({bus.rom_char_index, bus.rom_row_index} !== 10'd0) begin
      fails++; $display("FAIL reset_addr got %h want 000", {bus.rom_char_index, bus.rom_row_index});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_glyph(input bit inv, input logic [7:0] want, input string nm);
    int acc = -1, first = -1, lastp = -1, n = 0;
    logic [7:0] got = '0;
    bus.char_valid = 1'b1; bus.char_code = 7'h41; bus.char_row = 3'd0; bus.char_invert = inv;
    for (int c = 0; c < 16; c++) begin
      step();
      if (m_acc) begin acc = ecnt; bus.char_valid = 1'b0; end
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL %s_cycle edge%0d got %b want %b", nm, ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
      if (bus.pixel_valid) begin
        got = {got[6:0], bus.pixel};
        n++;
        if (first < 0) first = ecnt;
        if (bus.pixel_last) lastp = ecnt;
      end
    end
    tests++;
    if (got !== want) begin fails++; $display("FAIL %s_byte got %h want %h", nm, got, want); end
    tests++;
    if (n != 8) begin fails++; $display("FAIL %s_count got %0d want 8", nm, n); end
    // First pixel visible after the second edge following acceptance (cycle 3).
    tests++;
    if (first != acc + 2) begin fails++; $display("FAIL %s_latency got %0d want %0d", nm, first - acc, 2); end
    tests++;
    if (lastp != acc + 9) begin fails++; $display("FAIL %s_last got %0d want %0d", nm, lastp - acc, 9); end
  endtask

  task automatic test_back_to_back();
    int r = 0, n = 0, first = -1, lastv = -1, acc0 = -1;
    logic [63:0] stream = '0;
    bus.char_valid = 1'b1; bus.char_code = 7'h41; bus.char_row = 3'd0; bus.char_invert = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (m_acc) begin
        if (acc0 < 0) acc0 = ecnt;
        r++;
        if (r < 8) bus.char_row = r[2:0];
        else       bus.char_valid = 1'b0;
      end
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL b2b_cycle edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
      if (bus.pixel_valid) begin
        stream = {stream[62:0], bus.pixel};
        n++;
        if (first < 0) first = ecnt;
        lastv = ecnt;
      end
    end
    tests++;
    if (stream !== glyph_a) begin fails++; $display("FAIL b2b_stream got %h want %h", stream, glyph_a); end
    tests++;
    if (n != 64) begin fails++; $display("FAIL b2b_count got %0d want 64", n); end
    tests++;
    if (lastv - first != 63) begin fails++; $display("FAIL b2b_gapless got span %0d want 63", lastv - first); end
    tests++;
    if (first != acc0 + 2) begin fails++; $display("FAIL b2b_latency got %0d want 2", first - acc0); end
  endtask

  task automatic test_second_request();
    int acc1 = -1, acc2 = -1, n = 0, first = -1, lastv = -1;
    logic [6:0] c1, c2;
    logic [2:0] r1, r2;
    logic [15:0] stream = '0;
    logic [15:0] want;
    c1 = 7'($urandom); r1 = 3'($urandom); c2 = 7'($urandom); r2 = 3'($urandom);
    want = {rom[{c1, r1}], rom[{c2, r2}]};
    bus.char_valid = 1'b1; bus.char_code = c1; bus.char_row = r1; bus.char_invert = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (m_acc) begin
        if (acc1 < 0) begin
          acc1 = ecnt; bus.char_code = c2; bus.char_row = r2;
          tests++;
          if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL second_blocked got %b want 0", bus.char_ready); end
        end else begin
          acc2 = ecnt; bus.char_valid = 1'b0;
        end
      end
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL second_cycle edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
      if (bus.pixel_valid) begin
        stream = {stream[14:0], bus.pixel};
        n++;
        if (first < 0) first = ecnt;
        lastv = ecnt;
      end
    end
    tests++;
    if (acc2 != acc1 + 2) begin fails++; $display("FAIL second_accept got %0d want 2", acc2 - acc1); end
    tests++;
    if (stream !== want || n != 16) begin fails++; $display("FAIL second_stream got %h/%0d want %h/16", stream, n, want); end
    tests++;
    if (first != acc1 + 2 || lastv != acc1 + 17) begin
      fails++; $display("FAIL second_gapless got %0d..%0d want 2..17", first - acc1, lastv - acc1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, acc = -1, first = -1;
    logic [7:0] got = '0;
    bus.char_valid = 1'b1; bus.char_code = 7'($urandom); bus.char_row = 3'($urandom); bus.char_invert = 1'b0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (m_acc) bus.char_valid = 1'b0;
      if (bus.pixel_valid) n++;
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL midreset_setup got %0d pixels want 4", n); end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.pixel_valid, bus.pixel_last, bus.char_ready} !== 3'b001) begin
      fails++; $display("FAIL midreset_immediate got %b want 001", {bus.pixel_valid, bus.pixel_last, bus.char_ready});
    end
    model_clear();
    step(); step();
    reset_n = 1'b1;
    step();
    n = 0;
    bus.char_valid = 1'b1; bus.char_code = 7'h41; bus.char_row = 3'd3; bus.char_invert = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (m_acc) begin acc = ecnt; bus.char_valid = 1'b0; end
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL midreset_cycle edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
      if (bus.pixel_valid) begin
        got = {got[6:0], bus.pixel}; n++;
        if (first < 0) first = ecnt;
      end
    end
    tests++;
    if (got !== 8'hCC || n != 8) begin fails++; $display("FAIL midreset_glyph got %h/%0d want cc/8", got, n); end
    tests++;
    if (first != acc + 2) begin fails++; $display("FAIL midreset_latency got %0d want 2", first - acc); end
  endtask

  task automatic test_idle();
    logic [6:0] cq;
    logic [2:0] rq;
    int bad = 0;
    cq = 7'($urandom); rq = 3'($urandom);
    bus.char_valid = 1'b1; bus.char_code = cq; bus.char_row = rq; bus.char_invert = 1'($urandom);
    for (int c = 0; c < 12; c++) begin
      step();
      if (m_acc) bus.char_valid = 1'b0;
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL idle_glyph edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
    end
    for (int c = 0; c < 20; c++) begin
      bus.char_code = 7'($urandom); bus.char_row = 3'($urandom);
      step();
      tests++;
      if ({bus.pixel_valid, bus.char_ready, bus.rom_char_index, bus.rom_row_index} !== {1'b0, 1'b1, cq, rq}) begin
        fails++; bad++;
        $display("FAIL idle_hold edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.char_ready, bus.rom_char_index, bus.rom_row_index}, {1'b0, 1'b1, cq, rq});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.char_valid  = ($urandom_range(0, 3) != 0);
      bus.char_code   = 7'($urandom);
      bus.char_row    = 3'($urandom);
      bus.char_invert = 1'($urandom);
      step();
      tests++;
      if ({bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index}
          !== {e_pv, e_px, e_pl, m_ready, e_ci, e_ri}) begin
        fails++;
        $display("FAIL random_cycle edge%0d got %b want %b", ecnt,
          {bus.pixel_valid, bus.pixel, bus.pixel_last, bus.char_ready, bus.rom_char_index, bus.rom_row_index},
          {e_pv, e_px, e_pl, m_ready, e_ci, e_ri});
      end
    end
    bus.char_valid = 1'b0;
    for (int c = 0; c < 20; c++) step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int r = 0; r < 8; r++) rom[8*'h41 + r] = glyph_a[63-8*r -: 8];
    bus.rom_dout = '0;
    test_reset();
    test_glyph(1'b0, 8'h30, "single");
    test_glyph(1'b1, 8'hCF, "invert");
    test_back_to_back();
    test_second_request();
    test_reset_mid();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
